// File: rtl/pwm_duty_ramp.sv
// pwm_duty_ramp: duty-cycle sequencer for the PWM datapath.
// Accepts ramp commands (target, step, rate) over valid/ready and walks the
// registered duty output toward the target in fixed steps, updating only on
// PWM period boundaries so the datapath never sees a mid-period change.
module pwm_duty_ramp #(
    parameter int n     = 8,
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [n-1:0]     cmd_target,
    input  logic [n-1:0]     cmd_step,
    input  logic [DIV_W-1:0] cmd_rate,
    input  logic             abort,
    input  logic             period_tick,
    output logic [n-1:0]     duty,
    output logic             busy,
    output logic             done
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RAMP = 1'b1
    } state_t;

    localparam logic [n-1:0]     DUTY_ZERO = {n{1'b0}};
    localparam logic [n-1:0]     DUTY_ONE  = {{(n-1){1'b0}}, 1'b1};
    localparam logic [DIV_W-1:0] DIV_ZERO  = {DIV_W{1'b0}};
    localparam logic [DIV_W-1:0] DIV_ONE   = {{(DIV_W-1){1'b0}}, 1'b1};

    // Registered state and internals
    state_t             state_r;
    logic [n-1:0]       tgt_r;
    logic [n-1:0]       stp_r;
    logic [DIV_W-1:0]   rate_r;
    logic [DIV_W-1:0]   div_cnt_r;
    logic [n-1:0]       duty_r;
    logic               done_r;
    logic               busy_r;
    logic               ready_r;

    // Next-state values
    state_t             state_s;
    logic [n-1:0]       tgt_s;
    logic [n-1:0]       stp_s;
    logic [DIV_W-1:0]   rate_s;
    logic [DIV_W-1:0]   div_cnt_s;
    logic [n-1:0]       duty_s;
    logic               done_s;

    // Step arithmetic helpers
    logic               up_s;
    logic [n-1:0]       diff_s;
    logic [n-1:0]       stepped_s;
    logic [n-1:0]       cmd_step_fix_s;

    assign duty      = duty_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign cmd_ready = ready_r;

    // Distance to target and the candidate next duty, always moving toward tgt
    always_comb begin
        up_s      = (tgt_r > duty_r);
        diff_s    = DUTY_ZERO;
        stepped_s = duty_r;
        if (up_s) begin
            diff_s    = tgt_r - duty_r;
            stepped_s = duty_r + stp_r;
        end else begin
            diff_s    = duty_r - tgt_r;
            stepped_s = duty_r - stp_r;
        end
        if (cmd_step == DUTY_ZERO) begin
            cmd_step_fix_s = DUTY_ONE;
        end else begin
            cmd_step_fix_s = cmd_step;
        end
    end

    // Next-state logic: command accept in IDLE, tick-paced stepping and abort in RAMP
    always_comb begin
        state_s   = state_r;
        tgt_s     = tgt_r;
        stp_s     = stp_r;
        rate_s    = rate_r;
        div_cnt_s = div_cnt_r;
        duty_s    = duty_r;
        done_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cmd_valid) begin
                    tgt_s     = cmd_target;
                    stp_s     = cmd_step_fix_s;
                    rate_s    = cmd_rate;
                    div_cnt_s = DIV_ZERO;
                    if (cmd_target == duty_r) begin
                        done_s  = 1'b1;
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_RAMP;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RAMP: begin
                if (abort) begin
                    // abort wins over a coincident tick: duty freezes, no done
                    state_s = ST_IDLE;
                end else if (period_tick) begin
                    if (div_cnt_r != rate_r) begin
                        div_cnt_s = div_cnt_r + DIV_ONE;
                    end else begin
                        div_cnt_s = DIV_ZERO;
                        if (diff_s <= stp_r) begin
                            // final step lands exactly on the target
                            duty_s  = tgt_r;
                            done_s  = 1'b1;
                            state_s = ST_IDLE;
                        end else begin
                            duty_s  = stepped_s;
                            state_s = ST_RAMP;
                        end
                    end
                end else begin
                    state_s = ST_RAMP;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            tgt_r     <= DUTY_ZERO;
            stp_r     <= DUTY_ONE;
            rate_r    <= DIV_ZERO;
            div_cnt_r <= DIV_ZERO;
            duty_r    <= DUTY_ZERO;
            done_r    <= 1'b0;
            busy_r    <= 1'b0;
            ready_r   <= 1'b1;
        end else begin
            state_r   <= state_s;
            tgt_r     <= tgt_s;
            stp_r     <= stp_s;
            rate_r    <= rate_s;
            div_cnt_r <= div_cnt_s;
            duty_r    <= duty_s;
            done_r    <= done_s;
            busy_r    <= (state_s == ST_RAMP);
            ready_r   <= (state_s == ST_IDLE);
        end
    end

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Directed self-checking bench for pwm_duty_ramp: expected duty/done/busy
// values are queued as each cycle's stimulus is driven and compared after the edge.
module tb_pwm_duty_ramp;

    localparam int N        = 8;
    localparam int DW       = 8;
    localparam int TICK_GAP = 256;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [N-1:0]  cmd_target;
    logic [N-1:0]  cmd_step;
    logic [DW-1:0] cmd_rate;
    logic          abort;
    logic          period_tick;
    logic [N-1:0]  duty;
    logic          busy;
    logic          done;

    typedef struct {
        logic [N-1:0] duty;
        logic         done;
        logic         busy;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pwm_duty_ramp #(.n(N), .DIV_W(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_target (cmd_target),
        .cmd_step   (cmd_step),
        .cmd_rate   (cmd_rate),
        .abort      (abort),
        .period_tick(period_tick),
        .duty       (duty),
        .busy       (busy),
        .done       (done)
    );

    // Queue the expected outputs for the coming edge, clock once, then pop and compare.
    task automatic cyc(input string tag, input logic [N-1:0] d, input logic dn, input logic b);
        exp_t e;
        e.duty = d;
        e.done = dn;
        e.busy = b;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        checks++;
        assert (sb_q.size() > 0) else begin
            errors++;
            $error("FAIL %s scoreboard observed empty expected entry", tag);
        end
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checks++;
            assert (duty === e.duty) else begin
                errors++;
                $error("FAIL %s.duty observed %0d expected %0d", tag, duty, e.duty);
            end
            checks++;
            assert (done === e.done) else begin
                errors++;
                $error("FAIL %s.done observed %0b expected %0b", tag, done, e.done);
            end
            checks++;
            assert (busy === e.busy) else begin
                errors++;
                $error("FAIL %s.busy observed %0b expected %0b", tag, busy, e.busy);
            end
            checks++;
            assert (cmd_ready === !e.busy) else begin
                errors++;
                $error("FAIL %s.cmd_ready observed %0b expected %0b", tag, cmd_ready, !e.busy);
            end
        end
    endtask

    // Idle gap of one PWM period followed by a one-cycle period_tick.
    task automatic tick(input string tag, input logic [N-1:0] gap_d, input logic gap_b,
                        input logic [N-1:0] d, input logic dn, input logic b);
        for (int i = 0; i < TICK_GAP - 1; i++) begin
            cyc({tag, "_gap"}, gap_d, 1'b0, gap_b);
        end
        period_tick = 1'b1;
        cyc(tag, d, dn, b);
        period_tick = 1'b0;
    endtask

    task automatic send(input logic [N-1:0] t, input logic [N-1:0] s, input logic [DW-1:0] r);
        cmd_valid  = 1'b1;
        cmd_target = t;
        cmd_step   = s;
        cmd_rate   = r;
    endtask

    initial begin
        reset       = 1'b1;
        cmd_valid   = 1'b0;
        cmd_target  = 8'd0;
        cmd_step    = 8'd0;
        cmd_rate    = 8'd0;
        abort       = 1'b0;
        period_tick = 1'b0;

        // reset held for two cycles
        cyc("reset0", 8'd0, 1'b0, 1'b0);
        cyc("reset1", 8'd0, 1'b0, 1'b0);
        reset = 1'b0;
        cyc("post_reset", 8'd0, 1'b0, 1'b0);

        // up-ramp 0 -> 64, step 16, rate 0
        send(8'd64, 8'd16, 8'd0);
        cyc("up_accept", 8'd0, 1'b0, 1'b1);
        cmd_valid = 1'b0;
        tick("up_t1", 8'd0,  1'b1, 8'd16, 1'b0, 1'b1);
        tick("up_t2", 8'd16, 1'b1, 8'd32, 1'b0, 1'b1);
        tick("up_t3", 8'd32, 1'b1, 8'd48, 1'b0, 1'b1);
        tick("up_t4", 8'd48, 1'b1, 8'd64, 1'b1, 1'b0);
        cyc("up_after", 8'd64, 1'b0, 1'b0);

        // down-ramp 64 -> 10, step 20, rate 1: changes on even ticks only
        send(8'd10, 8'd20, 8'd1);
        cyc("dn_accept", 8'd64, 1'b0, 1'b1);
        cmd_valid = 1'b0;
        tick("dn_t1", 8'd64, 1'b1, 8'd64, 1'b0, 1'b1);
        tick("dn_t2", 8'd64, 1'b1, 8'd44, 1'b0, 1'b1);
        tick("dn_t3", 8'd44, 1'b1, 8'd44, 1'b0, 1'b1);
        tick("dn_t4", 8'd44, 1'b1, 8'd24, 1'b0, 1'b1);
        tick("dn_t5", 8'd24, 1'b1, 8'd24, 1'b0, 1'b1);
        tick("dn_t6", 8'd24, 1'b1, 8'd10, 1'b1, 1'b0);
        cyc("dn_after", 8'd10, 1'b0, 1'b0);

        // equal target: done on accept, back-to-back accepts, busy never rises
        send(8'd10, 8'd5, 8'd0);
        cyc("eq_accept1", 8'd10, 1'b1, 1'b0);
        cyc("eq_accept2", 8'd10, 1'b1, 1'b0);
        cmd_valid = 1'b0;
        cyc("eq_after", 8'd10, 1'b0, 1'b0);
        // tick in IDLE is ignored
        tick("idle_tick", 8'd10, 1'b0, 8'd10, 1'b0, 1'b0);

        // step 0 behaves as step 1
        send(8'd13, 8'd0, 8'd0);
        cyc("s0_accept", 8'd10, 1'b0, 1'b1);
        cmd_valid = 1'b0;
        tick("s0_t1", 8'd10, 1'b1, 8'd11, 1'b0, 1'b1);
        tick("s0_t2", 8'd11, 1'b1, 8'd12, 1'b0, 1'b1);
        tick("s0_t3", 8'd12, 1'b1, 8'd13, 1'b1, 1'b0);

        // return to 0 with a single oversized step
        send(8'd0, 8'd255, 8'd0);
        cyc("zero_accept", 8'd13, 1'b0, 1'b1);
        cmd_valid = 1'b0;
        tick("zero_t1", 8'd13, 1'b1, 8'd0, 1'b1, 1'b0);

        // ramp 0 -> 200 step 50; command during RAMP is ignored
        send(8'd200, 8'd50, 8'd0);
        cyc("ab_accept", 8'd0, 1'b0, 1'b1);
        cmd_valid = 1'b0;
        tick("ab_t1", 8'd0, 1'b1, 8'd50, 1'b0, 1'b1);
        send(8'd0, 8'd1, 8'd0);
        tick("ab_ign", 8'd50, 1'b1, 8'd100, 1'b0, 1'b1);
        cmd_valid = 1'b0;
        // abort coincident with a tick: duty frozen, no done
        for (int i = 0; i < TICK_GAP - 1; i++) begin
            cyc("ab_gap", 8'd100, 1'b0, 1'b1);
        end
        abort       = 1'b1;
        period_tick = 1'b1;
        cyc("ab_edge", 8'd100, 1'b0, 1'b0);
        abort       = 1'b0;
        period_tick = 1'b0;
        tick("ab_t_post1", 8'd100, 1'b0, 8'd100, 1'b0, 1'b0);
        tick("ab_t_post2", 8'd100, 1'b0, 8'd100, 1'b0, 1'b0);

        // reset mid-ramp at duty 48
        send(8'd0, 8'd52, 8'd0);
        cyc("rs_accept", 8'd100, 1'b0, 1'b1);
        cmd_valid = 1'b0;
        tick("rs_t1", 8'd100, 1'b1, 8'd48, 1'b0, 1'b1);
        cyc("rs_hold", 8'd48, 1'b0, 1'b1);
        reset = 1'b1;
        cyc("rs_edge", 8'd0, 1'b0, 1'b0);
        reset = 1'b0;
        tick("rs_t_post1", 8'd0, 1'b0, 8'd0, 1'b0, 1'b0);
        tick("rs_t_post2", 8'd0, 1'b0, 8'd0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
